// File: rtl/irq_controller.sv
// Wishbone-slave interrupt controller with synchronized irq inputs, pending/mask/mode/in-service registers and a vector port.
// Optional IRQ_ROTATE_EN: rotating priority driven by EOI, with the pointer readable at adr 6.
module irq_controller #(
  parameter int unsigned NUM_IRQ     = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cyc_i,
  input  logic               stb_i,
  input  logic               we_i,
  input  logic [3:0]         sel_i,
  input  logic [31:0]        adr_i,
  input  logic [31:0]        dat_i,
  output logic [31:0]        dat_o,
  output logic               ack_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  output logic               int_o
);

  typedef enum logic [2:0] {
    A_PEND = 3'd0, A_MASK = 3'd1, A_MODE = 3'd2, A_ISR  = 3'd3,
    A_VEC  = 3'd4, A_EOI  = 3'd5, A_PTR  = 3'd6, A_RSVD = 3'd7
  } addr_e;

  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
  logic [NUM_IRQ-1:0] s_prev_q, edge_q;
  logic [NUM_IRQ-1:0] pend_q, pend_d, mask_q, mask_d, mode_q, mode_d, isr_q, isr_d;
  logic [NUM_IRQ-1:0] clr, cand, s;
  logic [31:0]        dat_q, rdata;
  logic               ack_q;
  logic [3:0]         ptr, eoi_idx, win_idx;
  logic               cs, acc, wr, rd, vec_ack, eoi_hit, win_valid;
  addr_e              a;
  logic               unused;

  assign unused = ^{adr_i[31:5], adr_i[1:0], sel_i[3:1], dat_i};

`ifdef IRQ_ROTATE_EN
  logic [3:0] ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = '0;
`endif

  assign s       = sync_q[SYNC_STAGES-1];
  assign cand    = pend_q & ~mask_q;
  assign cs      = cyc_i & stb_i;
  assign acc     = cs & ~ack_q;
  assign wr      = acc & we_i & sel_i[0];
  assign rd      = acc & ~we_i;
  assign a       = addr_e'(adr_i[4:2]);
  assign eoi_idx = dat_i[3:0];

  // Ranks count cyclically from the pointer; an in-service line blocks its own rank and below.
  always_comb begin
    int unsigned blk_rank, best_rank, rank;
    blk_rank  = NUM_IRQ;
    best_rank = NUM_IRQ;
    win_valid = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      rank = (i >= 32'(ptr)) ? i - 32'(ptr) : i + NUM_IRQ - 32'(ptr);
      if (isr_q[i] && rank < blk_rank) blk_rank = rank;
    end
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      rank = (i >= 32'(ptr)) ? i - 32'(ptr) : i + NUM_IRQ - 32'(ptr);
      if (cand[i] && rank < best_rank && rank < blk_rank) begin
        best_rank = rank;
        win_valid = 1'b1;
        win_idx   = 4'(i);
      end
    end
  end

  assign int_o = win_valid;

  always_comb begin
    mask_d  = mask_q;
    mode_d  = mode_q;
    isr_d   = isr_q;
    pend_d  = pend_q;
    clr     = '0;
    eoi_hit = 1'b0;
    rdata   = '0;
    vec_ack = rd && (a == A_VEC) && win_valid;
    if (wr && a == A_MASK) mask_d = dat_i[NUM_IRQ-1:0];
    if (wr && a == A_MODE) mode_d = dat_i[NUM_IRQ-1:0];
    if (wr && a == A_PEND) clr    = dat_i[NUM_IRQ-1:0];
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (vec_ack && win_idx == 4'(i)) begin
        clr[i]   = 1'b1;
        isr_d[i] = 1'b1;
      end
      if (wr && a == A_EOI && eoi_idx == 4'(i) && isr_q[i]) begin
        isr_d[i] = 1'b0;
        eoi_hit  = 1'b1;
      end
      if (!mode_d[i])      pend_d[i] = s_prev_q[i];
      else if (!mode_q[i]) pend_d[i] = 1'b0;
      else                 pend_d[i] = (pend_q[i] & ~clr[i]) | edge_q[i];
    end
    case (a)
      A_PEND:  rdata = 32'(pend_q);
      A_MASK:  rdata = 32'(mask_q);
      A_MODE:  rdata = 32'(mode_q);
      A_ISR:   rdata = 32'(isr_q);
      A_VEC:   rdata = {win_valid, 27'd0, win_idx};
`ifdef IRQ_ROTATE_EN
      A_PTR:   rdata = 32'(ptr_q);
`endif
      default: rdata = '0;
    endcase
  end

`ifdef IRQ_ROTATE_EN
  always_comb begin
    ptr_d = ptr_q;
    if (eoi_hit) ptr_d = (eoi_idx == 4'(NUM_IRQ - 1)) ? 4'd0 : eoi_idx + 4'd1;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q   <= '0;
      s_prev_q <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
      mask_q   <= '1;
      mode_q   <= '0;
      isr_q    <= '0;
      ack_q    <= 1'b0;
      dat_q    <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], irq_i};
      s_prev_q <= s;
      edge_q   <= s & ~s_prev_q;
      pend_q   <= pend_d;
      mask_q   <= mask_d;
      mode_q   <= mode_d;
      isr_q    <= isr_d;
      ack_q    <= acc;
      if (rd) dat_q <= rdata;
    end
  end

  assign ack_o = ack_q;
  assign dat_o = dat_q;

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Wishbone-slave programmable interrupt controller that merges the PIT `int_o` and other peripheral interrupt lines into one CPU interrupt with a vector.
- Arbitrates simultaneous requests by priority, tracks in-service state for nesting, and sequences acknowledge/EOI with the CPU.
- Sits between the peripherals (PIT on line 0) and the MIPS core interrupt input.

Parameters:
- NUM_IRQ, 8, number of interrupt lines, legal 1..16.
- SYNC_STAGES, 2, synchronizer flops per irq input, legal 2..3.

Ports:
- clk_i  input  1  system clock.
- rst_i  input  1  asynchronous active-low reset.
- cyc_i  input  1  Wishbone cycle.
- stb_i  input  1  Wishbone strobe.
- we_i  input  1  write enable.
- sel_i  input  4  byte selects.
- adr_i  input  32  byte address; only [4:2] decoded.
- dat_i  input  32  write data.
- dat_o  output  32  registered read data.
- ack_o  output  1  Wishbone acknowledge.
- irq_i  input  NUM_IRQ  peripheral requests, asynchronous, active-high.
- int_o  output  1  interrupt request to the CPU.

Behaviour:
- Reset (rst_i=0, asynchronous): PEND=0, MASK=all ones, MODE=0, ISR=0, sync/edge flops=0, ack_o=0, dat_o=0, int_o=0.
- Bus handshake: cs=cyc_i&stb_i; ack_o <= cs & ~ack_o, so ack_o is a one-cycle pulse. With cs held, ack_o toggles every cycle. Register side effects and the dat_o load occur on the clock edge that raises ack_o. Writes take effect only if sel_i[0]=1; reads ignore sel_i. Unused dat_o bits read 0.
- Register map (adr_i[4:2]):
  - 0 PEND: read. Write-1-to-clear, edge lines only.
  - 1 MASK: read/write; 1 = masked.
  - 2 MODE: read/write; 1 = edge, 0 = level.
  - 3 ISR: read-only.
  - 4 VEC: read = interrupt acknowledge. Returns {valid in bit31, index in [3:0]}.
  - 5 EOI: write; dat_i[3:0] = index whose ISR bit is cleared.
  - 6–7: read 0, writes ignored.
- Input path: each irq_i passes through SYNC_STAGES flops, giving s.
  - Edge mode: PEND bit set on s rising (s & ~s_prev), registered. Stays set until W1C or VEC acknowledge.
  - Level mode: PEND bit = s; W1C and acknowledge do not clear it.
- Latency: an irq_i rise sampled at edge k sets PEND at edge k+SYNC_STAGES+1.
- int_o is combinational from registers: any unmasked PEND bit has higher priority than the highest-priority ISR bit.
- Priority: fixed, index 0 highest. A request of equal or lower priority than an in-service line is held off (no self-nesting).
- VEC read:
  - If a winner exists: returns valid=1 and the winner index, sets ISR[winner], clears PEND[winner] if edge mode.
  - Otherwise returns 0 with no state change.
  - The winner is computed from the register state present on the ack edge.
- EOI write: clears ISR[index]. Index ≥ NUM_IRQ or an ISR bit already 0 is ignored.
- Simultaneous events:
  - New edge and W1C/acknowledge clearing the same PEND bit in one cycle: set wins.
  - MASK write and VEC read cannot coincide (single bus port).
- Masking does not clear PEND; unmasking a pending line raises int_o on the next cycle.
- Changing MODE from level to edge loads PEND bit = 0 for that line.
- Mid-operation reset returns every register to its reset value immediately; a pending ack is lost.

Optional Feature:
- Macro: IRQ_ROTATE_EN.
- Defined: rotating priority. A pointer register (reset 0) names the highest-priority line. A valid EOI for index n sets the pointer to (n+1) mod NUM_IRQ. Priority then descends cyclically from the pointer. The pointer reads at adr 6, bits [3:0].
- Undefined: fixed priority as above; adr 6 reads 0.

Test Plan:
- Reset, read MASK/PEND/ISR -> 0x000000FF / 0 / 0; int_o=0; ack_o pulses exactly one cycle per access.
- MODE=0x01, MASK=0xFE, pulse irq_i[0] for 1 cycle -> PEND=0x01 after SYNC_STAGES+1 cycles, int_o=1. VEC read -> 0x80000000, ISR=0x01, PEND=0, int_o=0. EOI 0 -> ISR=0.
- Edge lines 0 and 3 both unmasked, line 3 in service -> irq 0 raises int_o (nesting); VEC returns 0x80000000; ISR=0x09.
- Line 5 in service, line 6 fires -> int_o stays 0 until EOI 5, then int_o=1 and VEC returns 0x80000006.
- Level line 2 held high, VEC read then EOI -> PEND bit 2 stays 1 and int_o reasserts. Deassert irq_i[2] -> PEND clears after sync latency.
- IRQ_ROTATE_EN: lines 0 and 1 both pending, acknowledge and EOI 0 -> next VEC returns 1; pointer reads 1.
